// File: rtl/byte_serializer_pkg.sv
// Shared types and defaults for the byte serializer.
// Holds the FSM state encoding and the default word width.
package byte_serializer_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with a one-word holding register.
// Words stream back-to-back when the hold register is refilled in time.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dataout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy,
  output logic [15:0]      word_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_word_count;

  logic w_shifting;
  logic w_last;
  logic w_accept;
  logic w_load;
  logic w_bit;

  assign w_shifting = (r_state == SHIFT);
  assign w_last     = w_shifting && (r_cnt == CW'(WIDTH - 1));
  assign w_accept   = din_valid && !r_hold_full;
  assign w_load     = r_hold_full && (!w_shifting || w_last);
  assign w_bit      = (MSB_FIRST != 0) ? r_shift[WIDTH-1]
                                       : r_shift[0];

  assign din_ready  = !r_hold_full;
  assign dataout    = w_shifting && w_bit;
  assign dout_valid = w_shifting;
  assign last       = w_last;
  assign busy       = w_shifting || r_hold_full;
  assign word_count = r_word_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold_full  <= 1'b0;
      r_hold       <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word_count <= '0;
    end else begin
      if (w_accept) begin
        r_hold <= din;
      end
      // accept wins on the flag; ready gating keeps it disjoint from load
      if (w_accept) begin
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (r_hold_full) begin
            r_state <= SHIFT;
            r_shift <= r_hold;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_word_count <= r_word_count + 16'd1;
            if (r_hold_full) begin
              r_shift <= r_hold;
              r_cnt   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (MSB_FIRST != 0) begin
              r_shift <= r_shift << 1;
            end else begin
              r_shift <= r_shift >> 1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: MSB and LSB instances.
// Inputs change and outputs are sampled on the falling edge.
module tb_byte_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        dataout;
  logic        dout_valid;
  logic        last;
  logic        busy;
  logic [15:0] word_count;

  logic [7:0]  din_l = '0;
  logic        din_valid_l = 1'b0;
  logic        din_ready_l;
  logic        dataout_l;
  logic        dout_valid_l;
  logic        last_l;
  logic        busy_l;
  logic [15:0] word_count_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset),
    .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dataout(dataout),
    .dout_valid(dout_valid), .last(last),
    .busy(busy), .word_count(word_count)
  );

  byte_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset),
    .din(din_l), .din_valid(din_valid_l),
    .din_ready(din_ready_l), .dataout(dataout_l),
    .dout_valid(dout_valid_l), .last(last_l),
    .busy(busy_l), .word_count(word_count_l)
  );

  task automatic do_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    din_valid_l = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (din_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", din_ready);
    end
    checks++;
    if (dataout !== 1'b0) begin
      errors++; $display("FAIL reset_dataout: got %b want 0", dataout);
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", dout_valid);
    end
    checks++;
    if (last !== 1'b0) begin
      errors++; $display("FAIL reset_last: got %b want 0", last);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (word_count !== 16'd0) begin
      errors++; $display("FAIL reset_wc: got %0d want 0", word_count);
    end
  endtask

  task automatic test_single_msb();
    logic [7:0] exp;
    exp = 8'hA3;
    do_reset();
    din = 8'hA3;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = 8'h00;
    checks++;
    if (busy !== 1'b1 || din_ready !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL msb_held: busy=%b ready=%b dv=%b want 1 0 0",
               busy, din_ready, dout_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b1 || dataout !== exp[7-i] ||
          last !== (i == 7)) begin
        errors++;
        $display("FAIL msb_bit%0d: dv=%b d=%b last=%b want 1 %b %b",
                 i, dout_valid, dataout, last, exp[7-i], (i == 7));
      end
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL msb_idle: dv=%b busy=%b ready=%b want 0 0 1",
               dout_valid, busy, din_ready);
    end
    checks++;
    if (word_count !== 16'd1) begin
      errors++; $display("FAIL msb_wc: got %0d want 1", word_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = 16'hA35C;
    do_reset();
    din = 8'hA3;
    din_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_full: got %b want 0", din_ready);
    end
    din = 8'h5C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b1 || dataout !== exp[15-i] ||
          last !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL b2b_bit%0d: dv=%b d=%b last=%b want 1 %b %b",
                 i, dout_valid, dataout, last, exp[15-i],
                 (i == 7 || i == 15));
      end
      checks++;
      if (din_ready !== (i == 0 || i >= 8)) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b want %b",
                 i, din_ready, (i == 0 || i >= 8));
      end
      if (i == 1) begin
        din_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || word_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_end: dv=%b wc=%0d want 0 2",
               dout_valid, word_count);
    end
  endtask

  task automatic test_lsb_first();
    do_reset();
    din_l = 8'h01;
    din_valid_l = 1'b1;
    @(negedge clk);
    din_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dout_valid_l !== 1'b1 || dataout_l !== (i == 0) ||
          last_l !== (i == 7)) begin
        errors++;
        $display("FAIL lsb_bit%0d: dv=%b d=%b last=%b want 1 %b %b",
                 i, dout_valid_l, dataout_l, last_l, (i == 0), (i == 7));
      end
    end
    @(negedge clk);
    checks++;
    if (dout_valid_l !== 1'b0 || word_count_l !== 16'd1) begin
      errors++;
      $display("FAIL lsb_end: dv=%b wc=%0d want 0 1",
               dout_valid_l, word_count_l);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    din = 8'hFF;
    din_valid = 1'b1;
    @(negedge clk);
    din = 8'h81;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b1 || dataout !== 1'b1) begin
        errors++;
        $display("FAIL mid_bit%0d: dv=%b d=%b want 1 1",
                 i, dout_valid, dataout);
      end
      if (i == 1) begin
        din_valid = 1'b0;
        checks++;
        if (din_ready !== 1'b0) begin
          errors++; $display("FAIL mid_held: ready=%b want 0", din_ready);
        end
      end
      if (i == 4) begin
        reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 ||
        din_ready !== 1'b1 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_after: dv=%b busy=%b ready=%b wc=%0d want 0 0 1 0",
               dout_valid, busy, din_ready, word_count);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (dout_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mid_leak: got %0d bits want 0", seen);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_word_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_word_count;
    @(negedge clk);
    checks++;
    if (word_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h want ffff", word_count);
    end
    din = 8'h3C;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (word_count !== 16'h0000 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count: wc=%h dv=%b want 0000 0",
               word_count, dout_valid);
    end
  endtask

  task automatic test_reset_handshake();
    int seen;
    do_reset();
    reset = 1'b1;
    din = 8'hFF;
    din_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    din_valid = 1'b0;
    checks++;
    if (din_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs: ready=%b busy=%b want 1 0", din_ready, busy);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (dout_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_hs_bits: got %0d want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid();
    test_wrap();
    test_reset_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
